hazard_sequencer: RTL and testbench

- Pipeline control for the 5-stage RISC-V core.
- Drives the execute stage's operand-forwarding selects and the stall/flush enables of the IF/ID/EX registers.
- Handles three events: load-use stalls, taken-branch flushes and multi-cycle ECC-correction freezes signalled by the memory stage.
- Keeps saturating stall and flush event counters for debug.

---
 rtl/core_ctrl_pkg.sv | 35 +++
 rtl/hazard_sequencer_if.sv | 46 ++++
 rtl/sat_counter.sv | 31 +++
 rtl/hazard_sequencer.sv | 117 +++++++++++
 tb/tb_hazard_sequencer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the core pipeline control logic.
// Holds the forwarding select encodings, the sequencer state enum and defaults.
package core_ctrl_pkg;

   localparam int unsigned REG_W       = 5;
   localparam int unsigned ECC_CNT_W   = 4;
   localparam int unsigned ECC_LAT_DEF = 2;
   localparam int unsigned CNT_W_DEF   = 16;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic {
      RUN      = 1'b0,
      ECC_WAIT = 1'b1
   } ctrl_state_e;

   // Operand source for one execute-stage register; the memory stage wins over writeback.
   function automatic logic [1:0] fwd_sel(input logic             wr_m,
                                          input logic [REG_W-1:0] rd_m,
                                          input logic             wr_w,
                                          input logic [REG_W-1:0] rd_w,
                                          input logic [REG_W-1:0] rs);
      logic [1:0] sel;
      sel = FWD_RF;
      if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
         sel = FWD_MEM;
      end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard sequencer.
// master drives the stage register/event inputs, slave produces the control outputs.
interface hazard_sequencer_if #(
   parameter int unsigned CNT_W = 16
);
   import core_ctrl_pkg::*;

   logic [REG_W-1:0] Rs1_D;
   logic [REG_W-1:0] Rs2_D;
   logic [REG_W-1:0] Rs1_E;
   logic [REG_W-1:0] Rs2_E;
   logic [REG_W-1:0] RD_E;
   logic             ResultSrcE;
   logic             RegWriteM;
   logic [REG_W-1:0] RD_M;
   logic             RegWriteW;
   logic [REG_W-1:0] RD_W;
   logic             PCSrcE;
   logic             EccErrM;

   logic [1:0]       ForwardA_E;
   logic [1:0]       ForwardB_E;
   logic             StallF;
   logic             StallD;
   logic             StallE;
   logic             FlushD;
   logic             FlushE;
   logic             EccBusy;
   logic [CNT_W-1:0] StallCount;
   logic [CNT_W-1:0] FlushCount;

   modport master (
      output Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, ResultSrcE,
             RegWriteM, RD_M, RegWriteW, RD_W, PCSrcE, EccErrM,
      input  ForwardA_E, ForwardB_E, StallF, StallD, StallE,
             FlushD, FlushE, EccBusy, StallCount, FlushCount
   );

   modport slave (
      input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, ResultSrcE,
             RegWriteM, RD_M, RegWriteW, RD_W, PCSrcE, EccErrM,
      output ForwardA_E, ForwardB_E, StallF, StallD, StallE,
             FlushD, FlushE, EccBusy, StallCount, FlushCount
   );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones maximum instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard control: operand forwarding, load-use stall, branch flush and
// ECC-correction freeze for the 5-stage core, plus saturating debug event counters.
module hazard_sequencer
   import core_ctrl_pkg::*;
#(
   parameter int unsigned ECC_LAT = ECC_LAT_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   hazard_sequencer_if.slave  hz
);

   ctrl_state_e          state_q;
   ctrl_state_e          state_d;
   logic [ECC_CNT_W-1:0] cnt_q;
   logic [ECC_CNT_W-1:0] cnt_d;

   logic lu;
   logic br;
   logic ecc;
   logic stall_f;
   logic stall_d;
   logic stall_e;
   logic flush_d;
   logic flush_e;
   logic busy;
   logic flush_evt;

   assign lu  = hz.ResultSrcE && (hz.RD_E != '0) &&
                ((hz.RD_E == hz.Rs1_D) || (hz.RD_E == hz.Rs2_D));
   assign br  = hz.PCSrcE;
   assign ecc = hz.EccErrM;

   // Next state and control decode; in RUN the priority is ecc > br > lu.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      stall_e   = 1'b0;
      flush_d   = 1'b0;
      flush_e   = 1'b0;
      busy      = 1'b0;
      flush_evt = 1'b0;
      case (state_q)
         RUN: begin
            if (ecc) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               cnt_d   = ECC_CNT_W'(ECC_LAT - 1);
               state_d = ECC_WAIT;
            end else if (br) begin
               flush_d   = 1'b1;
               flush_e   = 1'b1;
               flush_evt = 1'b1;
            end else if (lu) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
            end
         end
         ECC_WAIT: begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            busy    = 1'b1;
            if (cnt_q == ECC_CNT_W'(1)) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - ECC_CNT_W'(1);
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are combinational; reset holds them low without waiting for a clock.
   assign hz.ForwardA_E = rst ? fwd_sel(hz.RegWriteM, hz.RD_M, hz.RegWriteW, hz.RD_W, hz.Rs1_E)
                              : FWD_RF;
   assign hz.ForwardB_E = rst ? fwd_sel(hz.RegWriteM, hz.RD_M, hz.RegWriteW, hz.RD_W, hz.Rs2_E)
                              : FWD_RF;
   assign hz.StallF  = rst & stall_f;
   assign hz.StallD  = rst & stall_d;
   assign hz.StallE  = rst & stall_e;
   assign hz.FlushD  = rst & flush_d;
   assign hz.FlushE  = rst & flush_e;
   assign hz.EccBusy = rst & busy;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .rst_n   (rst),
      .inc_i   (stall_f),
      .count_o (hz.StallCount)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .rst_n   (rst),
      .inc_i   (flush_evt),
      .count_o (hz.FlushCount)
   );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_sequencer;
   import core_ctrl_pkg::*;

   localparam int unsigned LAT = 3;
   localparam int unsigned CW  = 4;
   localparam int          SAT = (1 << CW) - 1;

   typedef struct packed {
      logic [1:0] fa;
      logic [1:0] fb;
      logic       sf;
      logic       sd;
      logic       se;
      logic       fd;
      logic       fe;
      logic       busy;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   // Model state: cycles of freeze still owed after the current one, and event counts.
   int m_wait = 0;
   int m_sc   = 0;
   int m_fc   = 0;

   hazard_sequencer_if #(.CNT_W(CW)) hz ();

   hazard_sequencer #(.ECC_LAT(LAT), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [1:0] fa, input logic [1:0] fb,
                               input logic sf, input logic sd, input logic se,
                               input logic fd, input logic fe, input logic busy);
      return exp_t'({fa, fb, sf, sd, se, fd, fe, busy});
   endfunction

   function automatic exp_t obs();
      return mk(hz.ForwardA_E, hz.ForwardB_E, hz.StallF, hz.StallD, hz.StallE,
                hz.FlushD, hz.FlushE, hz.EccBusy);
   endfunction

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (rs == 5'd0) return 2'b00;
      if (hz.RegWriteM && hz.RD_M == rs) return 2'b10;
      if (hz.RegWriteW && hz.RD_W == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic exp_t ref_ctrl();
      exp_t e;
      logic load_use;
      e = '0;
      if (rst) begin
         e.fa = ref_fwd(hz.Rs1_E);
         e.fb = ref_fwd(hz.Rs2_E);
         load_use = hz.ResultSrcE && hz.RD_E != 0 &&
                    (hz.RD_E == hz.Rs1_D || hz.RD_E == hz.Rs2_D);
         if (m_wait > 0) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.busy = 1;
         end else if (hz.EccErrM) begin
            e.sf = 1; e.sd = 1; e.se = 1;
         end else if (hz.PCSrcE) begin
            e.fd = 1; e.fe = 1;
         end else if (load_use) begin
            e.sf = 1; e.sd = 1; e.fe = 1;
         end
      end
      return e;
   endfunction

   // Advance the model across the coming rising edge using the inputs now applied.
   task automatic model_tick(input exp_t e);
      if (e.sf && m_sc < SAT) m_sc++;
      if (m_wait == 0 && !hz.EccErrM && hz.PCSrcE && m_fc < SAT) m_fc++;
      if (m_wait > 0) m_wait--;
      else if (hz.EccErrM) m_wait = LAT - 1;
   endtask

   task automatic set_idle();
      hz.Rs1_D = 0; hz.Rs2_D = 0; hz.Rs1_E = 0; hz.Rs2_E = 0; hz.RD_E = 0;
      hz.ResultSrcE = 0; hz.RegWriteM = 0; hz.RD_M = 0; hz.RegWriteW = 0;
      hz.RD_W = 0; hz.PCSrcE = 0; hz.EccErrM = 0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      set_idle();
      m_wait = 0; m_sc = 0; m_fc = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      exp_t o;
      hz.Rs1_D = 3; hz.Rs2_D = 3; hz.Rs1_E = 5; hz.Rs2_E = 5; hz.RD_E = 3;
      hz.ResultSrcE = 1; hz.RegWriteM = 1; hz.RD_M = 5; hz.RegWriteW = 1;
      hz.RD_W = 5; hz.PCSrcE = 1; hz.EccErrM = 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #2;
         o = obs(); total++;
         if (o !== exp_t'(0)) begin
            bad++; $display("FAIL reset_outputs got=%b want=%b", o, exp_t'(0));
         end
         total++;
         if (hz.StallCount !== 0 || hz.FlushCount !== 0) begin
            bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", hz.StallCount, hz.FlushCount);
         end
      end
   endtask

   task automatic test_forwarding();
      exp_t o;
      exp_t w;
      do_reset();
      hz.RegWriteM = 1; hz.RD_M = 5; hz.RegWriteW = 1; hz.RD_W = 5;
      hz.Rs1_E = 5; hz.Rs2_E = 6; #2;
      o = obs(); w = mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0); total++;
      if (o !== w) begin bad++; $display("FAIL fwd_mem_wins got=%b want=%b", o, w); end
      hz.RD_M = 0; #2;
      o = obs(); w = mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0); total++;
      if (o !== w) begin bad++; $display("FAIL fwd_wb got=%b want=%b", o, w); end
      hz.RD_M = 6; #2;
      o = obs(); w = mk(2'b01, 2'b10, 0, 0, 0, 0, 0, 0); total++;
      if (o !== w) begin bad++; $display("FAIL fwd_split got=%b want=%b", o, w); end
      hz.RegWriteM = 0; hz.RegWriteW = 0; #2;
      o = obs(); w = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0); total++;
      if (o !== w) begin bad++; $display("FAIL fwd_no_write got=%b want=%b", o, w); end
      hz.RegWriteM = 1; hz.RD_M = 0; hz.RegWriteW = 1; hz.RD_W = 0;
      hz.Rs1_E = 0; hz.Rs2_E = 0; #2;
      o = obs(); w = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0); total++;
      if (o !== w) begin bad++; $display("FAIL fwd_x0 got=%b want=%b", o, w); end
   endtask

   task automatic test_load_use();
      exp_t o;
      exp_t w;
      do_reset();
      hz.ResultSrcE = 1; hz.RD_E = 3; hz.Rs2_D = 3; hz.Rs1_D = 1; #2;
      o = obs(); w = mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0); total++;
      if (o !== w) begin bad++; $display("FAIL lu_active got=%b want=%b", o, w); end
      @(negedge clk);
      set_idle(); #2;
      o = obs(); total++;
      if (o !== exp_t'(0)) begin bad++; $display("FAIL lu_released got=%b want=%b", o, exp_t'(0)); end
      total++;
      if (hz.StallCount !== 1) begin bad++; $display("FAIL lu_stallcount got=%0d want=1", hz.StallCount); end
      hz.ResultSrcE = 1; hz.RD_E = 0; hz.Rs1_D = 0; #2;
      o = obs(); total++;
      if (o !== exp_t'(0)) begin bad++; $display("FAIL lu_x0 got=%b want=%b", o, exp_t'(0)); end
   endtask

   task automatic test_branch_over_lu();
      exp_t o;
      exp_t w;
      do_reset();
      hz.ResultSrcE = 1; hz.RD_E = 3; hz.Rs2_D = 3; hz.PCSrcE = 1; #2;
      o = obs(); w = mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0); total++;
      if (o !== w) begin bad++; $display("FAIL br_over_lu got=%b want=%b", o, w); end
      @(negedge clk);
      set_idle(); #2;
      total++;
      if (hz.FlushCount !== 1 || hz.StallCount !== 0) begin
         bad++; $display("FAIL br_counts got=%0d/%0d want=1/0", hz.FlushCount, hz.StallCount);
      end
   endtask

   task automatic test_ecc_freeze();
      exp_t o;
      exp_t w;
      do_reset();
      hz.EccErrM = 1; #2;
      o = obs(); w = mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 0); total++;
      if (o !== w) begin bad++; $display("FAIL ecc_t got=%b want=%b", o, w); end
      @(negedge clk);
      hz.EccErrM = 0; hz.PCSrcE = 1; #2;
      o = obs(); w = mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1); total++;
      if (o !== w) begin bad++; $display("FAIL ecc_t1 got=%b want=%b", o, w); end
      @(negedge clk);
      hz.PCSrcE = 0; #2;
      o = obs(); total++;
      if (o !== w) begin bad++; $display("FAIL ecc_t2 got=%b want=%b", o, w); end
      @(negedge clk);
      #2;
      o = obs(); total++;
      if (o !== exp_t'(0)) begin bad++; $display("FAIL ecc_t3 got=%b want=%b", o, exp_t'(0)); end
      total++;
      if (hz.StallCount !== LAT || hz.FlushCount !== 0) begin
         bad++; $display("FAIL ecc_counts got=%0d/%0d want=%0d/0", hz.StallCount, hz.FlushCount, LAT);
      end
   endtask

   task automatic test_reset_mid_freeze();
      exp_t o;
      exp_t w;
      do_reset();
      hz.EccErrM = 1;
      @(negedge clk);
      hz.EccErrM = 0; #1;
      rst = 1'b0; #1;
      o = obs(); total++;
      if (o !== exp_t'(0)) begin bad++; $display("FAIL midrst_outputs got=%b want=%b", o, exp_t'(0)); end
      total++;
      if (hz.StallCount !== 0 || hz.FlushCount !== 0) begin
         bad++; $display("FAIL midrst_counts got=%0d/%0d want=0/0", hz.StallCount, hz.FlushCount);
      end
      @(negedge clk);
      rst = 1'b1; hz.PCSrcE = 1; #2;
      o = obs(); w = mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0); total++;
      if (o !== w) begin bad++; $display("FAIL midrst_run got=%b want=%b", o, w); end
   endtask

   task automatic test_saturation();
      do_reset();
      hz.ResultSrcE = 1; hz.RD_E = 7; hz.Rs1_D = 7;
      repeat (20) @(negedge clk);
      set_idle(); #2;
      total++;
      if (hz.StallCount !== CW'(SAT)) begin
         bad++; $display("FAIL sat_stallcount got=%0d want=%0d", hz.StallCount, SAT);
      end
   endtask

   task automatic test_random();
      exp_t o;
      exp_t e;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         hz.Rs1_D = 5'($urandom_range(0, 3)); hz.Rs2_D = 5'($urandom_range(0, 3));
         hz.Rs1_E = 5'($urandom_range(0, 3)); hz.Rs2_E = 5'($urandom_range(0, 3));
         hz.RD_E  = 5'($urandom_range(0, 3)); hz.RD_M  = 5'($urandom_range(0, 3));
         hz.RD_W  = 5'($urandom_range(0, 3));
         hz.ResultSrcE = 1'($urandom_range(0, 1));
         hz.RegWriteM  = 1'($urandom_range(0, 1));
         hz.RegWriteW  = 1'($urandom_range(0, 1));
         hz.PCSrcE     = ($urandom_range(0, 4) == 0);
         hz.EccErrM    = ($urandom_range(0, 9) == 0);
         #2;
         e = ref_ctrl();
         o = obs(); total++;
         if (o !== e) begin bad++; $display("FAIL rand_ctrl cyc=%0d got=%b want=%b", c, o, e); end
         total++;
         if (hz.StallCount !== CW'(m_sc)) begin
            bad++; $display("FAIL rand_stallcount cyc=%0d got=%0d want=%0d", c, hz.StallCount, m_sc);
         end
         total++;
         if (hz.FlushCount !== CW'(m_fc)) begin
            bad++; $display("FAIL rand_flushcount cyc=%0d got=%0d want=%0d", c, hz.FlushCount, m_fc);
         end
         model_tick(e);
         @(negedge clk);
      end
   endtask

   initial begin
      set_idle();
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_over_lu();
      test_ecc_freeze();
      test_reset_mid_freeze();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
